// File: rtl/md_pkg.sv
// Shared constants for the multiply/divide unit and the decode-side controller.
package md_pkg;

    localparam int unsigned MD_XLEN = 32;
    localparam int unsigned MD_OP_W = 3;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;
    localparam logic [MD_OP_W-1:0] MD_RSVD  = 3'd7;

    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_unit_if.sv
// E-stage handshake between the pipeline and the multiply/divide unit.
interface md_unit_if;
    import md_pkg::*;

    logic               start;
    logic [MD_OP_W-1:0] op;
    logic [MD_XLEN-1:0] rd1;
    logic [MD_XLEN-1:0] rd2;
    logic               busy;
    logic [MD_XLEN-1:0] HI;
    logic [MD_XLEN-1:0] LO;

    modport master (
        output start, op, rd1, rd2,
        input  busy, HI, LO
    );

    modport slave (
        input  start, op, rd1, rd2,
        output busy, HI, LO
    );

endinterface

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath; result is {hi, lo}.
module md_arith
    import md_pkg::*;
(
    input  logic [MD_OP_W-1:0]   op_i,
    input  logic [MD_XLEN-1:0]   a_i,
    input  logic [MD_XLEN-1:0]   b_i,
    output logic [2*MD_XLEN-1:0] result_o,
    output logic                 div_by_zero_o
);

    logic                        signed_div;
    logic                        a_neg;
    logic                        b_neg;
    logic [MD_XLEN-1:0]          a_mag;
    logic [MD_XLEN-1:0]          b_mag;
    logic [MD_XLEN-1:0]          divisor;
    logic [MD_XLEN-1:0]          q_mag;
    logic [MD_XLEN-1:0]          r_mag;
    logic [MD_XLEN-1:0]          quot;
    logic [MD_XLEN-1:0]          rem;
    logic signed [2*MD_XLEN-1:0] prod_s;
    logic [2*MD_XLEN-1:0]        prod_u;

    always_comb begin
        signed_div = (op_i == MD_DIV);
        a_neg      = signed_div & a_i[MD_XLEN-1];
        b_neg      = signed_div & b_i[MD_XLEN-1];
        a_mag      = a_neg ? -a_i : a_i;
        b_mag      = b_neg ? -b_i : b_i;
        // Divisor forced non-zero; a zero-divisor result is discarded upstream.
        divisor    = (b_i == '0) ? MD_XLEN'(1) : b_mag;
        q_mag      = a_mag / divisor;
        r_mag      = a_mag % divisor;
        quot       = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem        = a_neg ? -r_mag : r_mag;

        prod_s = $signed({{MD_XLEN{a_i[MD_XLEN-1]}}, a_i}) *
                 $signed({{MD_XLEN{b_i[MD_XLEN-1]}}, b_i});
        prod_u = {{MD_XLEN{1'b0}}, a_i} * {{MD_XLEN{1'b0}}, b_i};

        result_o      = '0;
        div_by_zero_o = 1'b0;
        case (op_i)
            MD_MULT:  result_o = prod_s;
            MD_MULTU: result_o = prod_u;
            MD_DIV, MD_DIVU: begin
                result_o      = {rem, quot};
                div_by_zero_o = (b_i == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide sequencer holding the architectural HI/LO registers.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  md
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    md_state_e              state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [MD_XLEN-1:0]     hi_q, hi_d;
    logic [MD_XLEN-1:0]     lo_q, lo_d;
    logic [MD_XLEN-1:0]     pend_hi_q, pend_hi_d;
    logic [MD_XLEN-1:0]     pend_lo_q, pend_lo_d;
    logic                   pend_dbz_q, pend_dbz_d;
    logic [2*MD_XLEN-1:0]   arith_result;
    logic                   arith_dbz;

    md_arith u_arith (
        .op_i          (md.op),
        .a_i           (md.rd1),
        .b_i           (md.rd2),
        .result_o      (arith_result),
        .div_by_zero_o (arith_dbz)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        pend_hi_d  = pend_hi_q;
        pend_lo_d  = pend_lo_q;
        pend_dbz_d = pend_dbz_q;

        unique case (state_q)
            StIdle: begin
                if (md.start) begin
                    case (md.op)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            pend_hi_d  = arith_result[2*MD_XLEN-1:MD_XLEN];
                            pend_lo_d  = arith_result[MD_XLEN-1:0];
                            pend_dbz_d = arith_dbz;
                            cnt_d      = ((md.op == MD_MULT) || (md.op == MD_MULTU)) ?
                                         CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
                            state_d    = StRun;
                        end
                        MD_MTHI: hi_d = md.rd1;
                        MD_MTLO: lo_d = md.rd1;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                cnt_d = cnt_q - CntW'(1);
                // Completion edge: counter goes from 1 to 0.
                if (cnt_q <= CntW'(1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (!pend_dbz_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            pend_hi_q  <= '0;
            pend_lo_q  <= '0;
            pend_dbz_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            pend_hi_q  <= pend_hi_d;
            pend_lo_q  <= pend_lo_d;
            pend_dbz_q <= pend_dbz_d;
        end
    end

    assign md.busy = (state_q == StRun);
    assign md.HI   = hi_q;
    assign md.LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: driver predicts HI/LO/busy, monitor compares every cycle.
module tb_md_unit;
    import md_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    typedef struct {
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_unit_if bus ();

    md_unit #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    exp_t        sb[$];
    int          cyc        = 0;
    int          checks     = 0;
    int          errors     = 0;
    bit          armed      = 1'b0;
    logic [31:0] m_hi       = '0;
    logic [31:0] m_lo       = '0;
    logic [31:0] vis_hi     = '0;
    logic [31:0] vis_lo     = '0;
    int          busy_from  = 0;
    int          busy_until = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    // Architectural reference: plain 64-bit arithmetic on the MIPS rules.
    function automatic void ref_model(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b, inout logic [31:0] hi,
                                      inout logic [31:0] lo, output int lat);
        longint p, sa, sd;
        lat = 0;
        case (op)
            MD_MULT: begin
                p  = longint'($signed(a)) * longint'($signed(b));
                hi = p[63:32];
                lo = p[31:0];
                lat = MULT_N;
            end
            MD_MULTU: begin
                p  = longint'({32'b0, a}) * longint'({32'b0, b});
                hi = p[63:32];
                lo = p[31:0];
                lat = MULT_N;
            end
            MD_DIV: begin
                lat = DIV_N;
                if (b != 0) begin
                    sa = longint'($signed(a));
                    sd = longint'($signed(b));
                    lo = 32'(sa / sd);
                    hi = 32'(sa % sd);
                end
            end
            MD_DIVU: begin
                lat = DIV_N;
                if (b != 0) begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            MD_MTHI: hi = a;
            MD_MTLO: lo = a;
            default: ;
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        int k;
        while (cyc < busy_until) step();
        bus.start = 1'b1;
        bus.op    = op;
        bus.rd1   = a;
        bus.rd2   = b;
        k = cyc + 1;
        ref_model(op, a, b, m_hi, m_lo, lat);
        if (lat > 0) begin
            busy_from  = k;
            busy_until = k + lat;
            sb.push_back('{k + lat, m_hi, m_lo});
        end else if (op == MD_MTHI || op == MD_MTLO) begin
            sb.push_back('{k, m_hi, m_lo});
        end
        step();
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.rd1   = $urandom;
        bus.rd2   = $urandom;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (armed) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e      = sb.pop_front();
                vis_hi = e.hi;
                vis_lo = e.lo;
            end
            chk("HI", bus.HI, vis_hi);
            chk("LO", bus.LO, vis_lo);
            chk("busy", 32'(bus.busy), (cyc >= busy_from && cyc < busy_until) ? 32'd1 : 32'd0);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin : driver
        logic [2:0]  op;
        logic [31:0] a, b;
        int          r;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = MD_NONE;
        bus.rd1   = '0;
        bus.rd2   = '0;
        repeat (3) step();
        reset = 1'b0;
        armed = 1'b1;

        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);

        issue(MD_MTHI, 32'h11, $urandom);
        issue(MD_MTLO, 32'h22, $urandom);
        issue(MD_DIVU, 32'd7, 32'd0);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

        issue(MD_MTHI, 32'hDEAD_BEEF, $urandom);
        issue(MD_MTLO, 32'h1234_5678, $urandom);
        issue(MD_NONE, $urandom, $urandom);
        issue(MD_RSVD, $urandom, $urandom);

        // Reset on the third busy cycle of a divide.
        issue(MD_DIV, 32'd1000, 32'd7);
        step();
        step();
        reset = 1'b1;
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        sb.push_back('{cyc + 1, 32'h0, 32'h0});
        busy_until = cyc + 1;
        step();
        reset = 1'b0;
        repeat (12) step();

        // A start during RUN must be ignored.
        issue(MD_MULT, 32'd1234, 32'd5678);
        step();
        bus.start = 1'b1;
        bus.op    = MD_MTHI;
        bus.rd1   = 32'h55;
        step();
        bus.start = 1'b0;

        repeat (60) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            r  = int'($urandom_range(0, 9));
            if (r == 0) b = '0;
            if (r == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if (r == 2) b = $urandom_range(1, 15);
            issue(op, a, b);
            if ($urandom_range(0, 3) == 0) step();
        end

        while (cyc < busy_until) step();
        repeat (3) step();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the pipelined MIPS core, in the E stage beside the ALU. It takes the forwarded E-stage operands and the decoded multiply/divide opcode, runs mult/multu/div/divu over a fixed multi-cycle latency, and holds the architectural HI/LO registers. Its outputs feed the HI/LO pipeline path into M and W, which mfhi/mflo use. Its `busy` output, OR'd with `start`, drives the stall logic in the hazard unit.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  qualifies `op` for one cycle.
- `op`  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op).
- `rd1`  in  32  operand A (rs), forwarded.
- `rd2`  in  32  operand B (rt), forwarded.
- `busy`  out  1  operation in flight.
- `HI`  out  32  architectural HI.
- `LO`  out  32  architectural LO.

## Operation
- Reset sets `HI`=0, `LO`=0, `busy`=0, cycle counter=0 and pending results=0. Reset wins over `start` in the same cycle.
- States: IDLE and RUN. `busy`=1 exactly when the unit is in RUN.
- **IDLE, start=1, op 1–4:**
  - Compute the 64-bit result from `rd1`/`rd2` as sampled at that edge and latch it into pending_hi/pending_lo.
  - Load the counter with MULT_CYCLES or DIV_CYCLES and enter RUN.
- **IDLE, start=1, op 5/6:** `HI` (op 5) or `LO` (op 6) takes `rd1` at that edge. State stays IDLE and `busy` stays 0.
- **RUN:** the counter decrements each edge. On the edge where it reaches 0, `HI`/`LO` take the pending values and the state returns to IDLE.
- `start` is ignored while in RUN; the hazard unit guarantees it is never asserted then. A `start` with op 0 or 7 is a no-op.
- Arithmetic:
  - mult: signed 32×32→64; HI=[63:32], LO=[31:0].
  - multu: unsigned 32×32→64.
  - div: signed. LO=quotient, truncated toward zero; HI=remainder, same sign as the dividend.
  - divu: unsigned.
- Division special cases:
  - Divisor 0: the operation still runs the full DIV_CYCLES, and `HI`/`LO` are left unchanged at completion.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- `HI`/`LO` keep their old values throughout RUN. Only the completion edge changes them.

## Timing
- `start` sampled at edge k → `busy`=1 from after edge k through edge k+N, where N is the op's latency. `HI`/`LO` are updated at edge k+N, when `busy` also falls.
- A new `start` is legal in the cycle right after `busy` falls, so back-to-back operations have no dead cycle.
- mthi/mtlo: the new value is visible one edge after `start`.
- Reset asserted during RUN: the next edge aborts the operation, `busy`=0, `HI`=`LO`=0 and the pending result is discarded.
- Outputs are purely registered. There is no combinational path from inputs to `busy`, `HI` or `LO`.

## Structure
- Shared package `md_pkg`:
  - op encodings `MD_NONE`…`MD_MTLO`
  - default latencies `MD_MULT_CYCLES`/`MD_DIV_CYCLES`
  - a 1-bit state encoding
- The decode-side controller imports the same op constants.
- Sub-module `md_arith`: combinational. Inputs are op and the two operands; outputs are the 64-bit result and a `div_by_zero` flag. The sequencing, counter and HI/LO registers stay in `md_unit`.

## Test plan
- **mult:** start, op=1, rd1=0xFFFFFFFE (−2), rd2=3 → `busy` high for 5 cycles → HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- **multu, back to back with div:**
  - multu 0xFFFFFFFF×2 → HI=1, LO=0xFFFFFFFE after 5 cycles.
  - Immediately after, div −7/2 → after 10 more cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. `HI`/`LO` hold the multu values during those 10 cycles.
- **Divide special cases:**
  - divu 7/0 with HI=0x11, LO=0x22 beforehand → 10 busy cycles, then HI=0x11, LO=0x22.
  - div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- **mthi/mtlo:**
  - mthi rd1=0xDEADBEEF → HI=0xDEADBEEF one edge later, `busy` never rises.
  - mtlo rd1=0x12345678 → LO updates and HI is untouched.
- **Reset during RUN:** reset at cycle 3 of a div → next edge `busy`=0, HI=LO=0. No late write-back appears in the following 10 cycles.
- **Start while busy:** pulse `start` with mthi 0x55 while a mult is running → ignored. Only the mult result lands, at the expected edge.
